ex_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline. It sits directly downstream of the decode stage, behind the ID/EX pipeline register. It takes the decoded ALU op, ALU select, two operands and the write-back target, and produces the write-back result combinationally. That result feeds both the EX/MEM register and the decode-stage forwarding inputs (`ex_wreg_i`, `ex_wd_i`, `ex_wdata_i`). It also owns the HI/LO registers and a multi-cycle iterative divider that stalls the pipeline while it runs.

---
 rtl/ex_stage.sv | 204 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: combinational ALU, HI/LO registers and a stalling 32-step restoring divider.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        flush_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
    localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

    div_state_e  state_q, state_d;
    logic [31:0] quot_q, quot_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_div, is_signed;
    logic [31:0] abs1, abs2;
    logic [32:0] trial, diff;
    logic        fits;
    logic [31:0] final_quot, final_rem;

    assign is_div    = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign is_signed = (aluop_i == EXE_DIV_OP);
    assign abs1      = (is_signed && reg1_i[31]) ? 32'd0 - reg1_i : reg1_i;
    assign abs2      = (is_signed && reg2_i[31]) ? 32'd0 - reg2_i : reg2_i;

    // The quotient register doubles as the dividend shift register: its MSB feeds the remainder.
    assign trial      = {rem_q[31:0], quot_q[31]};
    assign diff       = trial - {1'b0, dvs_q};
    assign fits       = trial >= {1'b0, dvs_q};
    assign final_quot = qneg_q ? 32'd0 - quot_q : quot_q;
    assign final_rem  = rneg_q ? 32'd0 - rem_q[31:0] : rem_q[31:0];

    always_comb begin
        state_d = state_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush_i) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (is_div) begin
                        if (reg2_i == 32'd0) begin
                            quot_d  = 32'hFFFF_FFFF;
                            rem_d   = {1'b0, reg1_i};
                            qneg_d  = 1'b0;
                            rneg_d  = 1'b0;
                            state_d = DIV_DONE;
                        end else begin
                            quot_d  = abs1;
                            rem_d   = 33'd0;
                            dvs_d   = abs2;
                            qneg_d  = is_signed && (reg1_i[31] ^ reg2_i[31]);
                            rneg_d  = is_signed && reg1_i[31];
                            cnt_d   = 6'd0;
                            state_d = DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    rem_d  = fits ? diff : trial;
                    quot_d = {quot_q[30:0], fits};
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    hi_d    = final_rem;
                    lo_d    = final_quot;
                    state_d = DIV_IDLE;
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            quot_q  <= 32'd0;
            rem_q   <= 33'd0;
            dvs_q   <= 32'd0;
            cnt_q   <= 6'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    logic [31:0] alu_res;
    logic        stall;

    always_comb begin
        alu_res = 32'd0;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                case (aluop_i)
                    EXE_OR_OP:  alu_res = reg1_i | reg2_i;
                    EXE_AND_OP: alu_res = reg1_i & reg2_i;
                    EXE_XOR_OP: alu_res = reg1_i ^ reg2_i;
                    EXE_NOR_OP: alu_res = ~(reg1_i | reg2_i);
                    default:    alu_res = 32'd0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop_i)
                    EXE_SLL_OP: alu_res = reg2_i << reg1_i[4:0];
                    EXE_SRL_OP: alu_res = reg2_i >> reg1_i[4:0];
                    EXE_SRA_OP: alu_res = 32'($signed(reg2_i) >>> reg1_i[4:0]);
                    default:    alu_res = 32'd0;
                endcase
            end
            EXE_RES_ARITH: begin
                case (aluop_i)
                    EXE_ADDU_OP: alu_res = reg1_i + reg2_i;
                    EXE_SUBU_OP: alu_res = reg1_i - reg2_i;
                    EXE_SLT_OP:  alu_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
                    default:     alu_res = 32'd0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (aluop_i)
                    EXE_MFHI_OP: alu_res = hi_q;
                    EXE_MFLO_OP: alu_res = lo_q;
                    default:     alu_res = 32'd0;
                endcase
            end
            default: alu_res = 32'd0;
        endcase
    end

    assign stall = is_div && (state_q != DIV_DONE);

    // Outputs are combinational, so reset has to mask them directly.
    always_comb begin
        wd_o       = 5'd0;
        wreg_o     = 1'b0;
        wdata_o    = 32'd0;
        stallreq_o = 1'b0;
        if (rst) begin
            wd_o       = wd_i;
            wreg_o     = wreg_i && !stall;
            wdata_o    = alu_res;
            stallreq_o = stall;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - Self-checking bench for ex_stage: vector table, randomized ALU/divide ops, abort sequences.
module tb_ex_stage;
    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_SLT  = 8'b0010_1010;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUBU = 8'b0010_0011;
    localparam logic [7:0] OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;
    localparam logic [2:0] S_LOGIC = 3'b001;
    localparam logic [2:0] S_SHIFT = 3'b010;
    localparam logic [2:0] S_MOVE  = 3'b011;
    localparam logic [2:0] S_ARITH = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i, flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic [31:0] hi_o, lo_o;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stallreq_o(stallreq_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = r1;
        reg2_i   = r2;
        wd_i     = wd;
        wreg_i   = wreg;
    endtask

    function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(a % 32);
        if (sel == S_LOGIC && op == OP_OR)   return a | b;
        if (sel == S_LOGIC && op == OP_AND)  return a & b;
        if (sel == S_LOGIC && op == OP_XOR)  return a ^ b;
        if (sel == S_LOGIC && op == OP_NOR)  return ~(a | b);
        if (sel == S_SHIFT && op == OP_SLL)  return b << sh;
        if (sel == S_SHIFT && op == OP_SRL)  return b >> sh;
        if (sel == S_SHIFT && op == OP_SRA)  return 32'($signed(b) >>> sh);
        if (sel == S_ARITH && op == OP_ADDU) return 32'(64'(a) + 64'(b));
        if (sel == S_ARITH && op == OP_SUBU) return 32'(64'(a) + 64'(~b) + 64'd1);
        if (sel == S_ARITH && op == OP_SLT)  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        if (sel == S_MOVE && op == OP_MFHI)  return model_hi;
        if (sel == S_MOVE && op == OP_MFLO)  return model_lo;
        return 32'd0;
    endfunction

    // Drives a divide, counts stall cycles up to DONE, then checks HI/LO after the ending edge.
    task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stalls,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        n = 0;
        drive(op, 3'b000, a, b, 5'd9, 1'b1);
        #1;
        chk({tag, " wreg_masked"}, {31'd0, wreg_o}, 32'd0);
        while (stallreq_o === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk({tag, " stall_cycles"}, 32'(n), 32'(exp_stalls));
        chk({tag, " wreg_done"}, {31'd0, wreg_o}, 32'd1);
        @(posedge clk);
        #1;
        model_hi = exp_hi;
        model_lo = exp_lo;
        chk({tag, " hi"}, hi_o, exp_hi);
        chk({tag, " lo"}, lo_o, exp_lo);
    endtask

    task automatic div_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op == OP_DIVU) begin
            q = a / b;
            r = a % b;
        end else begin
            q = 32'(int'(a) / int'(b));
            r = 32'(int'(a) % int'(b));
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[15];
    logic [7:0]  op_tab[12];
    logic [2:0]  sel_tab[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] q, r, a, b, e;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [4:0]  wd;
        logic        wreg;
        int          k;

        vecs[0]  = '{OP_OR,   S_LOGIC, 32'h0000_1100, 32'h0000_0020, 5'd5,  1'b1, 32'h0000_1120};
        vecs[1]  = '{OP_SRA,  S_SHIFT, 32'd4,         32'h8000_0000, 5'd1,  1'b1, 32'hF800_0000};
        vecs[2]  = '{OP_SLT,  S_ARITH, 32'hFFFF_FFFF, 32'd1,         5'd2,  1'b1, 32'd1};
        vecs[3]  = '{OP_SLT,  S_ARITH, 32'd1,         32'hFFFF_FFFF, 5'd3,  1'b0, 32'd0};
        vecs[4]  = '{OP_AND,  S_LOGIC, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd4,  1'b1, 32'h00F0_00F0};
        vecs[5]  = '{OP_XOR,  S_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd6,  1'b1, 32'hF0F0_0F0F};
        vecs[6]  = '{OP_NOR,  S_LOGIC, 32'h0000_FFFF, 32'h00FF_0000, 5'd7,  1'b1, 32'hFF00_0000};
        vecs[7]  = '{OP_SLL,  S_SHIFT, 32'h0000_0028, 32'h1234_5678, 5'd8,  1'b1, 32'h3456_7800};
        vecs[8]  = '{OP_SRL,  S_SHIFT, 32'd4,         32'h8000_0000, 5'd10, 1'b1, 32'h0800_0000};
        vecs[9]  = '{OP_ADDU, S_ARITH, 32'hFFFF_FFFF, 32'd2,         5'd11, 1'b1, 32'd1};
        vecs[10] = '{OP_SUBU, S_ARITH, 32'd0,         32'd1,         5'd12, 1'b1, 32'hFFFF_FFFF};
        vecs[11] = '{OP_OR,   3'b111,  32'h1234_5678, 32'h1,         5'd13, 1'b1, 32'd0};
        vecs[12] = '{OP_SRA,  S_SHIFT, 32'd31,        32'h4000_0000, 5'd14, 1'b0, 32'd0};
        vecs[13] = '{OP_MFHI, S_MOVE,  32'h0,         32'h0,         5'd15, 1'b1, 32'd0};
        vecs[14] = '{OP_MFLO, S_MOVE,  32'h0,         32'h0,         5'd31, 1'b1, 32'd0};

        op_tab  = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                    OP_ADDU, OP_SUBU, OP_SLT, OP_MFHI, OP_MFLO};
        sel_tab = '{S_LOGIC, S_LOGIC, S_LOGIC, S_LOGIC, S_SHIFT, S_SHIFT, S_SHIFT,
                    S_ARITH, S_ARITH, S_ARITH, S_MOVE, S_MOVE};

        rst     = 1'b0;
        flush_i = 1'b0;
        drive(OP_OR, S_LOGIC, 32'h1100, 32'h20, 5'd5, 1'b1);
        #3;
        chk("reset wdata", wdata_o, 32'd0);
        chk("reset wd", {27'd0, wd_o}, 32'd0);
        chk("reset wreg", {31'd0, wreg_o}, 32'd0);
        chk("reset stall", {31'd0, stallreq_o}, 32'd0);
        chk("reset hi", hi_o, 32'd0);
        chk("reset lo", lo_o, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].sel, vecs[i].r1, vecs[i].r2, vecs[i].wd, vecs[i].wreg);
            #1;
            chk($sformatf("vec%0d wdata", i), wdata_o, vecs[i].exp);
            chk($sformatf("vec%0d wd", i), {27'd0, wd_o}, {27'd0, vecs[i].wd});
            chk($sformatf("vec%0d wreg", i), {31'd0, wreg_o}, {31'd0, vecs[i].wreg});
            chk($sformatf("vec%0d stall", i), {31'd0, stallreq_o}, 32'd0);
            @(posedge clk);
            #1;
        end

        run_div("divu7_2", OP_DIVU, 32'd7, 32'd2, 33, 32'd1, 32'd3);
        drive(OP_MFLO, S_MOVE, 32'd0, 32'd0, 5'd3, 1'b1);
        #1;
        chk("mflo_after_div", wdata_o, 32'd3);
        @(posedge clk);
        #1;
        run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("div_by0", OP_DIV, 32'h0000_1234, 32'd0, 1, 32'h0000_1234, 32'hFFFF_FFFF);
        drive(OP_MFHI, S_MOVE, 32'd0, 32'd0, 5'd3, 1'b1);
        #1;
        chk("mfhi_after_div0", wdata_o, 32'h0000_1234);
        @(posedge clk);
        #1;

        for (int i = 0; i < 200; i++) begin
            k    = $urandom_range(0, 11);
            op   = op_tab[k];
            sel  = ($urandom_range(0, 15) == 0) ? 3'(5 + $urandom_range(0, 2)) : sel_tab[k];
            a    = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? 32'(0 - $urandom_range(0, 3)) : $urandom;
            wd   = 5'($urandom);
            wreg = 1'($urandom);
            e    = ref_alu(op, sel, a, b);
            drive(op, sel, a, b, wd, wreg);
            #1;
            n_cmp++;
            if (wdata_o !== e || wd_o !== wd || wreg_o !== wreg || stallreq_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d op=%h sel=%0d a=%h b=%h: got wdata=%h wd=%0d wreg=%b stall=%b, expected wdata=%h wd=%0d wreg=%b stall=0",
                         i, op, sel, a, b, wdata_o, wd_o, wreg_o, stallreq_o, e, wd, wreg);
            end
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 10; i++) begin
            op = $urandom_range(0, 1) ? OP_DIV : OP_DIVU;
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'(0 - $urandom_range(1, 9));
                default: b = $urandom;
            endcase
            if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            div_model(op, a, b, q, r);
            run_div($sformatf("rdiv%0d", i), op, a, b, (b == 32'd0) ? 1 : 33, r, q);
        end

        drive(OP_DIVU, 3'b000, 32'd100, 32'd7, 5'd9, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flush hi kept", hi_o, model_hi);
        chk("flush lo kept", lo_o, model_lo);
        run_div("after_flush", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);

        drive(OP_DIVU, 3'b000, 32'd55, 32'd4, 5'd9, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        drive(8'd0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_nop hi kept", hi_o, 32'd2);
        chk("flush_nop lo kept", lo_o, 32'd14);

        drive(OP_DIVU, 3'b000, 32'd50, 32'd3, 5'd9, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst wdata", wdata_o, 32'd0);
        chk("midrst wd", {27'd0, wd_o}, 32'd0);
        chk("midrst stall", {31'd0, stallreq_o}, 32'd0);
        chk("midrst hi", hi_o, 32'd0);
        chk("midrst lo", lo_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_hi = 32'd0;
        model_lo = 32'd0;
        drive(OP_MFHI, S_MOVE, 32'd0, 32'd0, 5'd2, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        chk("postrst mfhi", wdata_o, 32'd0);
        chk("postrst hi", hi_o, 32'd0);
        chk("postrst lo", lo_o, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
